// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared types and helpers for the hs_rr_arbiter slice.
// Holds the arbiter FSM encoding and the round-robin pointer wrap.
package hs_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      STALL = 2'd2
   } arb_state_e;

   // Next pointer after index p, wrapping by compare so that
   // non-power-of-two requester counts stay in range.
   function automatic int unsigned rr_next(
      input int unsigned p,
      input int unsigned nreq
   );
      if (p >= nreq - 1)
         return 0;
      else
         return p + 1;
   endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// hs_rr_pick: rotate-priority selector.
// First valid requester at or after ptr wins, wrapping modulo NREQ.
module hs_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   int             idx;
   logic [IDW-1:0] sel;

   // Scan from farthest to nearest so the nearest valid one sticks.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      idx    = 0;
      sel    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         sel = IDW'(idx);
         if (req_valid[sel]) begin
            gnt      = '0;
            gnt[sel] = 1'b1;
            gnt_id   = sel;
         end
      end
   end

endmodule

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin share of one busy/valid completer.
// Optional burst lock under macro HS_ARB_LOCK_EN (adds req_lock).
module hs_rr_arbiter #(
   parameter int  NREQ  = 4,
   parameter int  DSIZE = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rstn,
`ifdef HS_ARB_LOCK_EN
   input  logic [NREQ-1:0]       req_lock,
`endif
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_busy,
   input  logic                  cpl_busy,
   output logic                  cpl_valid,
   output logic [DSIZE-1:0]      cpl_data,
   output logic [IDW-1:0]        cpl_id
);

   import hs_arb_pkg::*;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_XFER  = XFER;
   localparam logic [1:0] ST_STALL = STALL;

   logic [IDW-1:0]  ptr;
   logic [1:0]      state;
   logic [1:0]      state_nxt;

   logic [NREQ-1:0] pick_gnt;
   logic [IDW-1:0]  pick_id;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            win;
   logic            lock_hit;
   logic [IDW-1:0]  ptr_nxt;

   hs_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .gnt       (pick_gnt),
      .gnt_id    (pick_id)
   );

`ifdef HS_ARB_LOCK_EN
   logic have_win;

   assign lock_hit = have_win
                   & req_lock[cpl_id]
                   & req_valid[cpl_id];

   // Remember that cpl_id names a real winner since reset.
   always_ff @(posedge clk) begin
      if (!rstn)
         have_win <= 1'b0;
      else if (win)
         have_win <= 1'b1;
   end
`else
   assign lock_hit = 1'b0;
`endif

   // A held lock overrides rotation and re-grants the last winner.
   always_comb begin
      gnt    = pick_gnt;
      gnt_id = pick_id;
      if (lock_hit) begin
         gnt         = '0;
         gnt[cpl_id] = 1'b1;
         gnt_id      = cpl_id;
      end
   end

   assign win = ~cpl_busy & (|req_valid);

   assign req_busy = {NREQ{cpl_busy}}
                   | (req_valid & ~gnt);

   // Locked beats keep the pointer so rotation resumes afterwards.
   always_comb begin
      ptr_nxt = ptr;
      if (win && !lock_hit)
         ptr_nxt = IDW'(rr_next(int'(gnt_id), NREQ));
   end

   // Register the winning beat toward the completer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cpl_valid <= 1'b0;
         cpl_data  <= '0;
         cpl_id    <= '0;
         ptr       <= '0;
      end else if (win) begin
         cpl_valid <= 1'b1;
         cpl_data  <= req_data[int'(gnt_id)*DSIZE +: DSIZE];
         cpl_id    <= gnt_id;
         ptr       <= ptr_nxt;
      end else begin
         cpl_valid <= 1'b0;
         cpl_data  <= '0;
      end
   end

   // Next-state: completer stall beats a grant, else idle.
   always_comb begin
      state_nxt = ST_IDLE;
      unique case (1'b1)
         cpl_busy: state_nxt = ST_STALL;
         win:      state_nxt = ST_XFER;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register, observed by checkers only.
   always_ff @(posedge clk) begin
      if (!rstn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: directed checks of hs_rr_arbiter (NREQ=4, DSIZE=4).
// Lock section compiles only with HS_ARB_LOCK_EN.
module tb_hs_rr_arbiter;

   import hs_arb_pkg::*;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_lock;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_busy;
   logic        cpl_busy;
   logic        cpl_valid;
   logic [3:0]  cpl_data;
   logic [1:0]  cpl_id;

   int tests = 0;
   int fails = 0;

   hs_rr_arbiter #(
      .NREQ  (4),
      .DSIZE (4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
`ifdef HS_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_busy  (req_busy),
      .cpl_busy  (cpl_busy),
      .cpl_valid (cpl_valid),
      .cpl_data  (cpl_data),
      .cpl_id    (cpl_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(
      input string      tag,
      input logic       v,
      input logic [1:0] id,
      input logic [3:0] d
   );
      chk({tag, "_v"}, 32'(cpl_valid), 32'(v));
      chk({tag, "_id"}, 32'(cpl_id), 32'(id));
      chk({tag, "_d"}, 32'(cpl_data), 32'(d));
   endtask

   int f_id [5] = '{0, 1, 2, 3, 0};
   int f_d  [5] = '{1, 2, 3, 4, 1};
   int f_b  [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

   initial begin
      rstn      = 1'b0;
      req_lock  = 4'b0000;
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      cpl_busy  = 1'b0;

      // reset held two cycles with all requesters valid
      tick();
      chk_beat("rst0", 1'b0, 2'd0, 4'h0);
      tick();
      chk_beat("rst1", 1'b0, 2'd0, 4'h0);
      chk("rst_busy", 32'(req_busy), 32'(4'b1110));
      chk("rst_st", 32'(dut.state), 32'(IDLE));

      // fairness: 0,1,2,3,0
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_beat($sformatf("fair%0d", i), 1'b1,
                  2'(f_id[i]), 4'(f_d[i]));
         chk($sformatf("fair%0d_busy", i),
             32'(req_busy), 32'(f_b[i]));
      end
      chk("fair_st", 32'(dut.state), 32'(XFER));

      // stall: ptr=1, valid 0101 -> id 2 wins first
      req_valid = 4'b0101;
      #1;
      chk("pre_stall_busy", 32'(req_busy), 32'(4'b0001));
      tick();
      chk_beat("pre_stall", 1'b1, 2'd2, 4'h3);
      cpl_busy = 1'b1;
      #1;
      chk("stall_busy", 32'(req_busy), 32'(4'b1111));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_beat($sformatf("stall%0d", i), 1'b0, 2'd2, 4'h0);
         chk($sformatf("stall%0d_st", i),
             32'(dut.state), 32'(STALL));
      end
      cpl_busy = 1'b0;
      #1;
      chk("rel_busy", 32'(req_busy), 32'(4'b0100));
      tick();
      chk_beat("rel0", 1'b1, 2'd0, 4'h1);
      tick();
      chk_beat("rel1", 1'b1, 2'd2, 4'h3);

      // wrap: ptr=3, valid 1001 -> 3,0,3
      req_valid = 4'b1001;
      tick();
      chk_beat("wrap0", 1'b1, 2'd3, 4'h4);
      tick();
      chk_beat("wrap1", 1'b1, 2'd0, 4'h1);
      tick();
      chk_beat("wrap2", 1'b1, 2'd3, 4'h4);

      // idle then launch from requester 2
      req_valid = 4'b0000;
      #1;
      chk("idle_busy", 32'(req_busy), 32'(4'b0000));
      tick();
      chk_beat("idle", 1'b0, 2'd3, 4'h0);
      chk("idle_st", 32'(dut.state), 32'(IDLE));
      req_valid = 4'b0100;
      req_data  = 16'h0A00;
      #1;
      chk("launch_busy", 32'(req_busy), 32'(4'b0000));
      tick();
      chk_beat("launch", 1'b1, 2'd2, 4'hA);

      // reset mid-stream: beat dropped, pointer back to 0
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      rstn      = 1'b0;
      tick();
      chk_beat("mrst", 1'b0, 2'd0, 4'h0);
      rstn = 1'b1;
      tick();
      chk_beat("mrst_rel", 1'b1, 2'd0, 4'h1);

`ifdef HS_ARB_LOCK_EN
      // requester 1 locks a 4-beat burst, then 2 takes over
      req_lock = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_beat($sformatf("lock%0d", i), 1'b1, 2'd1, 4'h2);
      end
      req_lock = 4'b0000;
      tick();
      chk_beat("unlock", 1'b1, 2'd2, 4'h3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
